// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI master byte sequencer.
package spi_seq_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RX = 2'd2
  } seq_state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with flush; full/empty come
// from the registered count only, so a pop never makes room for a same-cycle push.
module spi_byte_fifo
  import spi_seq_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Clear,
  input  logic              i_Wr_En,
  input  logic [DATA_W-1:0] i_Wr_Byte,
  output logic              o_Full,
  input  logic              i_Rd_En,
  output logic [DATA_W-1:0] o_Rd_Byte,
  output logic              o_Empty,
  output logic [CW-1:0]     o_Count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              wr_ok, rd_ok;

  assign o_Full    = (o_Count == CW'(DEPTH));
  assign o_Empty   = (o_Count == '0);
  assign wr_ok     = i_Wr_En && !o_Full && !i_Clear;
  assign rd_ok     = i_Rd_En && !o_Empty && !i_Clear;
  assign o_Rd_Byte = o_Empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and count alone
  // define which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge i_Clk) begin
    if (wr_ok) mem[wr_ptr] <= i_Wr_Byte;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_Count <= '0;
    end else if (i_Clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_Count <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   o_Count <= o_Count + CW'(1);
        2'b01:   o_Count <= o_Count - CW'(1);
        default: o_Count <= o_Count;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_byte_sequencer.sv
// Feeds buffered host bytes to the SPI master one at a time, collects the
// returned bytes, and aborts a transfer the master never answers.
module spi_master_byte_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Clear,
  input  logic [DATA_W-1:0] i_Wr_Byte,
  input  logic              i_Wr_En,
  output logic              o_Wr_Full,
  output logic [DATA_W-1:0] o_Rd_Byte,
  input  logic              i_Rd_En,
  output logic              o_Rd_Empty,
  output logic [DATA_W-1:0] o_TX_Byte,
  output logic              o_TX_DV,
  input  logic              i_TX_Ready,
  input  logic              i_RX_DV,
  input  logic [DATA_W-1:0] i_RX_Byte,
  output logic              o_Busy,
  output logic              o_Err_Timeout
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  seq_state_t        state, state_next;
  logic [CW-1:0]     tx_count, rx_count;
  logic [DATA_W-1:0] tx_head;
  logic [WD_W-1:0]   wd_cnt;
  logic              tx_empty, rx_full_unused;
  logic              issue_ok, wd_expired, tx_pop, rx_push;

  // Only one byte is ever in flight, so free RX space now guarantees room for its reply.
  assign issue_ok   = !tx_empty && i_TX_Ready && (rx_count < CW'(DEPTH));
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign o_Busy     = (state != IDLE) || (tx_count != '0);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    if (i_Clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (issue_ok) state_next = ISSUE;
        ISSUE:   state_next = WAIT_RX;
        WAIT_RX: if (i_RX_DV || wd_expired) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_TX_DV = (state == ISSUE);
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    if (!i_Clear) begin
      tx_pop  = (state == IDLE) && issue_ok;
      rx_push = (state == WAIT_RX) && i_RX_DV;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_TX_Byte     <= '0;
      wd_cnt        <= '0;
      o_Err_Timeout <= 1'b0;
    end else if (i_Clear) begin
      o_TX_Byte     <= '0;
      wd_cnt        <= '0;
      o_Err_Timeout <= 1'b0;
    end else begin
      if (tx_pop) o_TX_Byte <= tx_head;
      if (state == ISSUE)        wd_cnt <= '0;
      else if (state == WAIT_RX) wd_cnt <= wd_cnt + WD_W'(1);
      if (state == WAIT_RX && !i_RX_DV && wd_expired) o_Err_Timeout <= 1'b1;
    end
  end

  spi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Clear   (i_Clear),
    .i_Wr_En   (i_Wr_En),
    .i_Wr_Byte (i_Wr_Byte),
    .o_Full    (o_Wr_Full),
    .i_Rd_En   (tx_pop),
    .o_Rd_Byte (tx_head),
    .o_Empty   (tx_empty),
    .o_Count   (tx_count)
  );

  spi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Clear   (i_Clear),
    .i_Wr_En   (rx_push),
    .i_Wr_Byte (i_RX_Byte),
    .o_Full    (rx_full_unused),
    .i_Rd_En   (i_Rd_En),
    .o_Rd_Byte (o_Rd_Byte),
    .o_Empty   (o_Rd_Empty),
    .o_Count   (rx_count)
  );

endmodule

// File: tb/tb_spi_master_byte_sequencer.sv
// Scoreboard bench: stimulus queues expected TX issues and RX reads, a monitor
// compares them as the DUT presents them, and a small SPI master model echoes bytes.
module tb_spi_master_byte_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic       i_Clk = 1'b0;
  logic       i_Rst, i_Clear, i_Wr_En, i_Rd_En, i_TX_Ready, i_RX_DV;
  logic [7:0] i_Wr_Byte, i_RX_Byte;
  logic       o_Wr_Full, o_Rd_Empty, o_TX_DV, o_Busy, o_Err_Timeout;
  logic [7:0] o_Rd_Byte, o_TX_Byte;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         tx_seen = 0;
  int         stray_req  = 0;
  int         stray_done = 0;
  logic       echo_en    = 1'b0;
  int         echo_delay = 2;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  always #5 i_Clk = ~i_Clk;

  spi_master_byte_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_Clear       (i_Clear),
    .i_Wr_Byte     (i_Wr_Byte),
    .i_Wr_En       (i_Wr_En),
    .o_Wr_Full     (o_Wr_Full),
    .o_Rd_Byte     (o_Rd_Byte),
    .i_Rd_En       (i_Rd_En),
    .o_Rd_Empty    (o_Rd_Empty),
    .o_TX_Byte     (o_TX_Byte),
    .o_TX_DV       (o_TX_DV),
    .i_TX_Ready    (i_TX_Ready),
    .i_RX_DV       (i_RX_DV),
    .i_RX_Byte     (i_RX_Byte),
    .o_Busy        (o_Busy),
    .o_Err_Timeout (o_Err_Timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  a_tx_dv_pulse: assert property (@(posedge i_Clk) disable iff (i_Rst) o_TX_DV |=> !o_TX_DV)
    else begin
      n_fail++;
      $display("FAIL tx_dv_pulse: o_TX_DV high two cycles in a row");
    end

  // Monitor: compares every issue and every host read against the scoreboard.
  always @(negedge i_Clk) begin
    if (!i_Rst) begin
      if (o_TX_DV) begin
        tx_seen++;
        if (exp_tx.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_issue: unexpected byte 0x%0h issued", o_TX_Byte);
        end else begin
          check("tx_issue_byte", o_TX_Byte, exp_tx.pop_front());
        end
      end
      if (i_Rd_En && !o_Rd_Empty) begin
        if (exp_rx.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rx_read: unexpected byte 0x%0h read", o_Rd_Byte);
        end else begin
          check("rx_read_byte", o_Rd_Byte, exp_rx.pop_front());
        end
      end
    end
  end

  // SPI master model: echoes issued byte ^ 8'h99 after echo_delay clocks, or sends a stray pulse.
  initial begin
    logic [7:0] b;
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'h00;
    forever begin
      @(negedge i_Clk);
      if (stray_req != stray_done) begin
        @(posedge i_Clk); #1;
        i_RX_DV = 1'b1; i_RX_Byte = 8'hEE;
        @(posedge i_Clk); #1;
        i_RX_DV = 1'b0;
        stray_done++;
      end else if (o_TX_DV && echo_en && !i_Rst) begin
        b = o_TX_Byte ^ 8'h99;
        repeat (echo_delay) @(posedge i_Clk);
        #1;
        i_RX_DV = 1'b1; i_RX_Byte = b;
        @(posedge i_Clk); #1;
        i_RX_DV = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic write_byte(input logic [7:0] b, input bit accept, input bit echo);
    i_Wr_Byte = b; i_Wr_En = 1'b1;
    @(posedge i_Clk); #1;
    i_Wr_En = 1'b0;
    if (accept) exp_tx.push_back(b);
    if (accept && echo) exp_rx.push_back(b ^ 8'h99);
  endtask

  task automatic read_one();
    i_Rd_En = 1'b1;
    @(posedge i_Clk); #1;
    i_Rd_En = 1'b0;
  endtask

  // Leaves the bench on the falling edge of the cycle where o_TX_DV is high.
  task automatic wait_tx_dv(input string name);
    for (int k = 0; k < 100; k++) begin
      @(negedge i_Clk);
      if (o_TX_DV) break;
    end
    check(name, o_TX_DV, 1'b1);
  endtask

  task automatic wait_rx_avail(input string name);
    for (int k = 0; k < 100 && o_Rd_Empty; k++) begin
      @(posedge i_Clk); #1;
    end
    check(name, o_Rd_Empty, 1'b0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_tx_dv"},  o_TX_DV, 1'b0);
    check({name, "_tx_byte"}, o_TX_Byte, 8'h00);
    check({name, "_wr_full"}, o_Wr_Full, 1'b0);
    check({name, "_rd_byte"}, o_Rd_Byte, 8'h00);
    check({name, "_rd_empty"}, o_Rd_Empty, 1'b1);
    check({name, "_busy"},    o_Busy, 1'b0);
    check({name, "_err"},     o_Err_Timeout, 1'b0);
  endtask

  initial begin
    int start_seen;
    i_Rst = 1'b1; i_Clear = 1'b0; i_Wr_En = 1'b0; i_Rd_En = 1'b0;
    i_TX_Ready = 1'b1; i_Wr_Byte = 8'h00;
    repeat (2) @(posedge i_Clk);
    #1;
    check_idle_outputs("reset");
    i_Rst = 1'b0;
    @(posedge i_Clk); #1;

    // Test 1: reset while waiting for the reply, then a stray RX pulse.
    write_byte(8'h5A, 1'b1, 1'b0);
    wait_tx_dv("t1_issue_seen");
    repeat (3) @(posedge i_Clk);
    #3;
    i_Rst = 1'b1;
    #1;
    check_idle_outputs("t1_midreset");
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    @(posedge i_Clk); #1;
    stray_req++;
    for (int k = 0; k < 20 && stray_done != stray_req; k++) begin
      @(posedge i_Clk); #1;
    end
    check("t1_stray_done", stray_done, stray_req);
    @(posedge i_Clk); #1;
    check("t1_stray_ignored", o_Rd_Empty, 1'b1);
    check("t1_busy_after", o_Busy, 1'b0);

    // Test 2: single byte, latency N+2, echo at exactly the watchdog limit.
    echo_en = 1'b1; echo_delay = 16;
    write_byte(8'hA5, 1'b1, 1'b1);
    @(negedge i_Clk);
    check("t2_dv_low_n1", o_TX_DV, 1'b0);
    check("t2_busy", o_Busy, 1'b1);
    @(negedge i_Clk);
    check("t2_dv_high_n2", o_TX_DV, 1'b1);
    check("t2_tx_byte", o_TX_Byte, 8'hA5);
    @(negedge i_Clk);
    check("t2_dv_low_n3", o_TX_DV, 1'b0);
    @(posedge i_Clk); #1;
    wait_rx_avail("t2_rx_arrived");
    check("t2_rd_byte", o_Rd_Byte, 8'h3C);
    check("t2_no_timeout", o_Err_Timeout, 1'b0);
    read_one();
    check("t2_rx_empty", o_Rd_Empty, 1'b1);

    // Test 3: overfill TX with master not ready, then drain in order.
    echo_en = 1'b0; echo_delay = 2;
    i_TX_Ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("t3_not_full_early", o_Wr_Full, 1'b0);
      write_byte(8'h10 + 8'(i), 1'b1, 1'b1);
    end
    check("t3_full", o_Wr_Full, 1'b1);
    write_byte(8'h18, 1'b0, 1'b0);
    check("t3_still_full", o_Wr_Full, 1'b1);
    start_seen = tx_seen;
    echo_en = 1'b1;
    i_TX_Ready = 1'b1;
    for (int k = 0; k < 500 && exp_tx.size() != 0; k++) begin
      @(posedge i_Clk); #1;
    end
    repeat (6) @(posedge i_Clk);
    #1;
    check("t3_issue_count", tx_seen - start_seen, DEPTH);
    check("t3_tx_drained", o_Busy, 1'b0);
    check("t3_not_full", o_Wr_Full, 1'b0);

    // Test 4: RX full withholds issue; one read restores it; write on full+pop dropped.
    start_seen = tx_seen;
    write_byte(8'h20, 1'b1, 1'b1);
    repeat (10) @(posedge i_Clk);
    #1;
    check("t4_withheld", tx_seen - start_seen, 0);
    check("t4_busy", o_Busy, 1'b1);
    for (int i = 1; i < DEPTH; i++) write_byte(8'h20 + 8'(i), 1'b1, 1'b1);
    check("t4_tx_full", o_Wr_Full, 1'b1);
    read_one();
    write_byte(8'h28, 1'b0, 1'b0);
    check("t4_pop_not_full", o_Wr_Full, 1'b0);
    for (int k = 0; k < 3000 && (exp_rx.size() != 0 || exp_tx.size() != 0); k++) begin
      i_Rd_En = !o_Rd_Empty;
      @(posedge i_Clk); #1;
    end
    i_Rd_En = 1'b0;
    repeat (6) @(posedge i_Clk);
    #1;
    check("t4_rx_drained", exp_rx.size(), 0);
    check("t4_idle", o_Busy, 1'b0);
    check("t4_rx_empty", o_Rd_Empty, 1'b1);

    // Test 5: watchdog expiry, sticky flag, recovery, clear.
    echo_en = 1'b0;
    write_byte(8'h55, 1'b1, 1'b0);
    wait_tx_dv("t5_issue_seen");
    repeat (TIMEOUT) @(negedge i_Clk);
    check("t5_err_before", o_Err_Timeout, 1'b0);
    @(negedge i_Clk);
    check("t5_err_set", o_Err_Timeout, 1'b1);
    check("t5_idle_after_abort", o_Busy, 1'b0);
    @(posedge i_Clk); #1;
    echo_en = 1'b1; echo_delay = 3;
    write_byte(8'h66, 1'b1, 1'b1);
    wait_rx_avail("t5_next_rx");
    check("t5_next_rd_byte", o_Rd_Byte, 8'hFF);
    read_one();
    check("t5_err_sticky", o_Err_Timeout, 1'b1);
    i_Clear = 1'b1;
    @(posedge i_Clk); #1;
    i_Clear = 1'b0;
    check("t5_err_cleared", o_Err_Timeout, 1'b0);
    check("t5_clear_tx_byte", o_TX_Byte, 8'h00);

    // Test 6: RX push and host pop in the same cycle.
    echo_delay = 2;
    write_byte(8'h71, 1'b1, 1'b1);
    wait_rx_avail("t6_first_rx");
    write_byte(8'h72, 1'b1, 1'b1);
    wait_tx_dv("t6_issue_seen");
    repeat (2) @(posedge i_Clk);
    #1;
    check("t6_rx_dv_now", i_RX_DV, 1'b1);
    read_one();
    check("t6_count_kept", o_Rd_Empty, 1'b0);
    check("t6_order", o_Rd_Byte, 8'hEB);
    read_one();
    check("t6_empty_after", o_Rd_Empty, 1'b1);

    repeat (4) @(posedge i_Clk);
    #1;
    check("end_tx_queue", exp_tx.size(), 0);
    check("end_rx_queue", exp_rx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
